fixed_weight_tile_source: RTL

Parameter-side producer for the transformer attention/linear blocks. Stores one weight (or bias) tensor as a sequence of parallelism-sized tiles loaded once over a valid/ready load port. It then replays the full tile sequence on a valid/ready output stream a programmable number of times, one replay per input-activation pass. It sits in front of each `weight_*` / `bias_*` port of the self-attention core.

---
 rtl/weight_streaming_pkg.sv | 31 +++
 rtl/fixed_weight_tile_source_if.sv | 40 ++++
 rtl/weight_tile_ram.sv | 41 ++++
 rtl/fixed_weight_tile_source.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_streaming_pkg.sv
// ============================================================================
//  Module      : weight_streaming_pkg
//  Description : Shared types and sizing helpers for the fixed weight tile
//                source (state encoding, tile depth, pointer width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package weight_streaming_pkg;

    // Controller states: waiting for a tensor, holding one, replaying it
    typedef enum logic [1:0] {
        WTS_EMPTY  = 2'd0,
        WTS_LOADED = 2'd1,
        WTS_STREAM = 2'd2
    } wts_state_t;

    // Number of tiles needed to cover the tensor
    function automatic int calc_depth(input int t0, input int t1,
                                      input int p0, input int p1);
        return (t0 / p0) * (t1 / p1);
    endfunction

    // Address width for a tile store of the given depth (never below 1 bit)
    function automatic int calc_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_weight_tile_source_if.sv
// ============================================================================
//  Module      : fixed_weight_tile_source_if
//  Description : Load port, replay control and output stream of the fixed
//                weight tile source. master = controller/consumer side,
//                slave = the tile source itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fixed_weight_tile_source_if #(
    parameter int PRECISION_0 = 8,
    parameter int ELEMS       = 8,
    parameter int PASS_WIDTH  = 16
) ();

    logic [ELEMS-1:0][PRECISION_0-1:0] load_data;
    logic                              load_valid;
    logic                              load_ready;
    logic                              clear;
    logic                              start;
    logic [PASS_WIDTH-1:0]             num_passes;
    logic                              busy;
    logic                              done;
    logic [ELEMS-1:0][PRECISION_0-1:0] weight;
    logic                              weight_valid;
    logic                              weight_ready;

    modport master (
        output load_data, load_valid, clear, start, num_passes, weight_ready,
        input  load_ready, busy, done, weight, weight_valid
    );

    modport slave (
        input  load_data, load_valid, clear, start, num_passes, weight_ready,
        output load_ready, busy, done, weight, weight_valid
    );

endinterface

`default_nettype wire

// File: rtl/weight_tile_ram.sv
// ============================================================================
//  Module      : weight_tile_ram
//  Description : Simple dual-port tile store, one write port and one
//                registered read port. Storage is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_tile_ram #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, data appears the cycle after re
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fixed_weight_tile_source.sv
// ============================================================================
//  Module      : fixed_weight_tile_source
//  Description : Stores one weight/bias tensor as a sequence of tiles and
//                replays it a programmable number of times on a
//                valid/ready stream through a 2-entry skid FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_weight_tile_source
    import weight_streaming_pkg::*;
#(
    parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 8,
    parameter int WEIGHT_TENSOR_SIZE_DIM_1 = 8,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 4,
    parameter int WEIGHT_PARALLELISM_DIM_1 = 2,
    parameter int WEIGHT_PRECISION_0       = 8,
    parameter int PASS_WIDTH               = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    fixed_weight_tile_source_if.slave bus
);

    localparam int ELEMS = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
    localparam int DEPTH = calc_depth(WEIGHT_TENSOR_SIZE_DIM_0, WEIGHT_TENSOR_SIZE_DIM_1,
                                      WEIGHT_PARALLELISM_DIM_0, WEIGHT_PARALLELISM_DIM_1);
    localparam int PTR_W = calc_ptr_width(DEPTH);
    localparam int WIDTH = WEIGHT_PRECISION_0 * ELEMS;
    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);

    wts_state_t            state;
    wts_state_t            state_nx;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic [PASS_WIDTH-1:0] passes;
    logic                  issuing;        // reads remain to be issued
    logic                  inflight;       // RAM output valid this cycle
    logic                  inflight_last;  // ... and it is the final tile
    logic                  done_q;

    logic [WIDTH-1:0]      ram_rdata;
    logic [1:0][WIDTH-1:0] fifo_data;
    logic [1:0]            fifo_last;
    logic                  head;
    logic                  tail;
    logic [1:0]            count;

    logic                  load_fire;
    logic                  load_final;
    logic                  pop;
    logic                  final_pop;
    logic                  issue;
    logic                  issue_last;
    logic                  start_ok;
    logic [2:0]            level_after;

    assign load_fire  = (state == WTS_EMPTY) && bus.load_valid;
    assign load_final = load_fire && (wr_ptr == LAST_ADDR);
    assign start_ok   = (state == WTS_LOADED) && !bus.clear && bus.start;

    assign pop        = (count != 2'd0) && bus.weight_ready;
    assign final_pop  = pop && fifo_last[head];
    assign issue_last = (rd_ptr == LAST_ADDR) && (pass_cnt == passes - PASS_WIDTH'(1));

    // Occupancy after this cycle's push/pop; counting the pop as freed space
    // is what lets a read go out every cycle while the consumer drains.
    assign level_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (state == WTS_STREAM) && issuing && (level_after < 3'd2);

    assign bus.done         = done_q;
    assign bus.weight_valid = (count != 2'd0);
    assign bus.weight       = fifo_data[head];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WTS_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nx       = state;
        bus.load_ready = 1'b0;
        bus.busy       = 1'b0;
        case (state)
            WTS_EMPTY: begin
                bus.load_ready = 1'b1;
                if (load_final) begin
                    state_nx = WTS_LOADED;
                end
            end
            WTS_LOADED: begin
                if (bus.clear) begin
                    state_nx = WTS_EMPTY;
                end else if (bus.start && (bus.num_passes != '0)) begin
                    state_nx = WTS_STREAM;
                end
            end
            WTS_STREAM: begin
                bus.busy = 1'b1;
                if (final_pop) begin
                    state_nx = WTS_LOADED;
                end
            end
            default: begin
                state_nx = WTS_EMPTY;
            end
        endcase
    end

    // Load write pointer, rewinds after the last tile
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else if (load_fire) begin
            wr_ptr <= load_final ? '0 : wr_ptr + PTR_W'(1);
        end
    end

    // Read issue sequencing across tiles and passes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            pass_cnt <= '0;
            passes   <= '0;
            issuing  <= 1'b0;
        end else if (start_ok && (bus.num_passes != '0)) begin
            rd_ptr   <= '0;
            pass_cnt <= '0;
            passes   <= bus.num_passes;
            issuing  <= 1'b1;
        end else if (issue) begin
            if (issue_last) begin
                issuing <= 1'b0;
            end
            if (rd_ptr == LAST_ADDR) begin
                rd_ptr   <= '0;
                pass_cnt <= pass_cnt + PASS_WIDTH'(1);
            end else begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Track the read in flight through the RAM output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && issue_last;
        end
    end

    // Completion pulse: final tile accepted, or a zero-pass request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= final_pop || (start_ok && (bus.num_passes == '0));
        end
    end

    // Two-entry skid FIFO between the RAM and the output stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_data <= '0;
            fifo_last <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_data[tail] <= ram_rdata;
                fifo_last[tail] <= inflight_last;
                tail            <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    weight_tile_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (load_fire),
        .waddr (wr_ptr),
        .wdata (bus.load_data),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

endmodule

`default_nettype wire
